arf_frame_loader: RTL
=====================

# arf_frame_loader

Input staging block for the ARF datapath. Accepts a serial stream of 16-bit samples over a valid/ready handshake and assembles eight of them into a frame. Presents each frame in parallel as the eight first-operand inputs of the first-level multipliers (multipliers 1–8). Two frame banks are used in ping-pong fashion, so one frame can be collected while the previous one is held for the datapath.

## Interface

Parameters:
- DATA_W, 16, sample width in bits.
- N_TAPS, 8, samples per frame (one per first-level multiplier).
- CNT_W, 8, width of the frame counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  upstream sample valid.
- s_ready  output  1  loader can accept a sample this cycle.
- s_data  input  DATA_W  sample value, two's complement.
- flush  input  1  discard a partially filled frame.
- m_valid  output  1  complete frame available.
- m_ready  input  1  datapath consumes the frame this cycle.
- m_data  output  N_TAPS*DATA_W  frame; lane k = m_data[k*DATA_W +: DATA_W]; lane 0 drives multiplier 1 … lane 7 drives multiplier 8.
- frame_cnt  output  CNT_W  number of frames delivered, modulo 2^CNT_W.
- fill_level  output  log2(N_TAPS)+1  samples held in the bank currently being written.

## Operation

- Storage: bank[0..1][0..N_TAPS-1], plus per-bank flag full[0..1], write pointer wr_ptr, write bank select wr_bank and read bank select rd_bank.
- s_ready = !full[wr_bank] && !flush.
- Accept rule: s_valid && s_ready writes s_data into bank[wr_bank][wr_ptr] and increments wr_ptr.
- When wr_ptr == N_TAPS-1 on an accept: set full[wr_bank], toggle wr_bank, reset wr_ptr to 0.
- m_valid = full[rd_bank]; m_data = bank[rd_bank], held stable while m_valid && !m_ready.
- Consume rule: m_valid && m_ready clears full[rd_bank], toggles rd_bank and increments frame_cnt. frame_cnt wraps from 2^CNT_W-1 to 0.
- Per-bank states are EMPTY, FILLING and FULL.
  - EMPTY→FILLING on the first accept.
  - FILLING→FULL on the N_TAPS-th accept.
  - FULL→EMPTY on consume.
- Invariant: at most one bank is in FILLING.
- Flush sets wr_ptr to 0 and leaves full banks untouched; samples from the partial frame are lost. Flush during an idle or empty bank has no effect.
- Fill and consume in the same cycle on different banks are both honoured.
- When both banks are full, s_ready stays 0 until one consume.
- fill_level = wr_ptr. It reads 0 when full[wr_bank].
- No arithmetic is performed on data; samples pass through bit-exact. Coefficient operands are outside this block.

## Timing

- Reset (rst_n low, asynchronous) clears the following: both full flags, wr_ptr, wr_bank, rd_bank, frame_cnt, and all bank contents to 0.
- Output values during reset: m_valid=0, s_ready=1 (if flush=0), m_data=0, frame_cnt=0, fill_level=0.
- Release of rst_n takes effect on the next rising edge.
- s_ready and m_valid are combinational decodes of registered state only. They have no path from s_valid or m_ready.
- Latency: if the N_TAPS-th sample is accepted on edge t, m_valid is high after edge t and m_data holds that frame.
- Sustained throughput is one sample per cycle. With m_ready tied high, one frame leaves every N_TAPS cycles and there are no bubbles on s_ready.
- Reset asserted mid-frame or mid-hold discards all data. No partial frame is ever emitted afterward.
- Sample order within a frame is arrival order: the first accepted sample goes to lane 0.

## Test plan

- Reset then stream samples 1..8 with m_ready=1 → m_valid high one edge after the 8th accept; lanes 0..7 = 1..8; frame_cnt becomes 1 after the consume edge.
- Stream 24 samples continuously with m_ready=0 → after 16 accepts s_ready=0; m_data = frame 1..8 held stable. Raising m_ready for one cycle delivers 1..8, then 9..16 appears, and s_ready returns to 1.
- Accept 5 samples, pulse flush, then send 100..107 → delivered frame lanes = 100..107; fill_level reads 5, then 0 after flush.
- Random s_valid/m_ready toggling over 1000 samples → frames are delivered in order with no loss or duplication; frame_cnt = 125 at the end.
- Assert rst_n low while one bank is full and the other holds 3 samples → m_valid=0, fill_level=0 and frame_cnt=0 immediately. The next 8 samples form a clean frame.
- Deliver 256 frames → frame_cnt wraps to 0.

Source files
------------

// File: rtl/arf_frame_loader.sv
// Ping-pong frame loader: packs N_TAPS serial samples into one parallel frame for the first-level multipliers.
// Frame is valid the edge after its last sample is accepted; s_ready drops only when both banks hold full frames.
module arf_frame_loader #(
  parameter  int DATA_W = 16,
  parameter  int N_TAPS = 8,
  parameter  int CNT_W  = 8,
  localparam int PTR_W  = $clog2(N_TAPS) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     flush,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [N_TAPS*DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]         frame_cnt,
  output logic [PTR_W-1:0]         fill_level
);

  localparam int IDX_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } bank_st_t;

  bank_st_t          r_state [2];
  logic [DATA_W-1:0] r_bank  [2][N_TAPS];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [CNT_W-1:0]  r_frame_cnt;

  logic w_wr_full;
  logic w_accept;
  logic w_consume;
  logic w_last;

  // Handshake decodes look only at registered state, never at s_valid/m_ready.
  assign w_wr_full = (r_state[r_wr_bank] == ST_FULL);
  assign s_ready   = !w_wr_full && !flush;
  assign m_valid   = (r_state[r_rd_bank] == ST_FULL);
  assign w_accept  = s_valid && s_ready;
  assign w_consume = m_valid && m_ready;
  assign w_last    = (r_wr_ptr == PTR_W'(N_TAPS - 1));

  assign frame_cnt  = r_frame_cnt;
  assign fill_level = w_wr_full ? '0 : r_wr_ptr;

  always_comb begin
    m_data = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      m_data[k*DATA_W +: DATA_W] = r_bank[r_rd_bank][k];
    end
  end

  // Accept and consume always target different banks, so both may update in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        r_state[b] <= ST_EMPTY;
        for (int k = 0; k < N_TAPS; k++) begin
          r_bank[b][k] <= '0;
        end
      end
      r_wr_ptr    <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_bank[r_wr_bank][r_wr_ptr[IDX_W-1:0]] <= s_data;
        if (w_last) begin
          r_state[r_wr_bank] <= ST_FULL;
          r_wr_bank          <= ~r_wr_bank;
          r_wr_ptr           <= '0;
        end else begin
          r_state[r_wr_bank] <= ST_FILLING;
          r_wr_ptr           <= r_wr_ptr + PTR_W'(1);
        end
      end else if (flush) begin
        r_wr_ptr <= '0;
        if (r_state[r_wr_bank] == ST_FILLING) begin
          r_state[r_wr_bank] <= ST_EMPTY;
        end
      end

      if (w_consume) begin
        r_state[r_rd_bank] <= ST_EMPTY;
        r_rd_bank          <= ~r_rd_bank;
        r_frame_cnt        <= r_frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule
